transaction_forwarder: RTL and testbench



---
 rtl/transaction_forwarder.sv | 176 +++++++++++++++++
 tb/tb_transaction_forwarder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transaction_forwarder.sv
// -----------------------------------------------------------------------------
// transaction_forwarder
//
// Drains one transaction from one of NUMBER_OF_QUEUES first-word-fall-through
// queues onto a single registered valid/ready output channel. The scheduler
// starts a transaction with a one-cycle `enable` pulse and a queue `id`. The
// block then moves the head beats of that queue into the output register, one
// per cycle, until it has loaded a last beat. A last beat is one flagged by
// lastElem, or the MAX_BEATS-th beat of the transaction. When the last beat
// has been accepted downstream, `consumed` pulses for one cycle.
//
// Ports
//   clock           : single clock, all logic on posedge
//   reset           : asynchronous, active-low reset
//   enable, id      : start pulse and queue to drain (id sampled with enable)
//   ready           : high while idle and able to accept a new transaction
//   consumed        : one-cycle pulse once the transaction has completed
//   empty           : per-queue empty flags
//   lastElem        : per-queue "head beat ends its transaction" flags
//   heads           : per-queue head data (first-word-fall-through)
//   pop             : one-hot head-removal strobe, asserted in the load cycle
//   m_data, m_last,
//   m_valid, m_ready: registered output channel
//   beats_forwarded : free-running, wrapping count of accepted output beats
//   protocol_error  : sticky, set when enable arrives while not idle
// -----------------------------------------------------------------------------
module transaction_forwarder #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int MAX_BEATS        = 16,
    parameter int REGISTER_SIZE    = 32,
    localparam int ID_W            = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        enable,
    input  logic [ID_W-1:0]                             id,
    output logic                                        ready,
    output logic                                        consumed,
    input  logic [NUMBER_OF_QUEUES-1:0]                 empty,
    input  logic [NUMBER_OF_QUEUES-1:0]                 lastElem,
    input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] heads,
    output logic [NUMBER_OF_QUEUES-1:0]                 pop,
    output logic [DATA_WIDTH-1:0]                       m_data,
    output logic                                        m_last,
    output logic                                        m_valid,
    input  logic                                        m_ready,
    output logic [REGISTER_SIZE-1:0]                    beats_forwarded,
    output logic                                        protocol_error
);

    localparam int BC_W = $clog2(MAX_BEATS + 1);
    localparam logic [ID_W:0] NQ_L = (ID_W + 1)'(NUMBER_OF_QUEUES);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [ID_W-1:0]        cur_id;
    logic [BC_W-1:0]        beat_cnt;
    logic                   last_loaded;

    logic                   id_ok;
    logic                   cur_empty;
    logic                   cur_last;
    logic [DATA_WIDTH-1:0]  cur_head;
    logic                   force_last;
    logic                   load;
    logic                   handshake;

    // An id outside the queue range looks like a queue that never fills.
    assign id_ok      = ({1'b0, cur_id} < NQ_L);
    assign cur_empty  = id_ok ? empty[cur_id]    : 1'b1;
    assign cur_last   = id_ok ? lastElem[cur_id] : 1'b0;
    assign cur_head   = id_ok ? heads[cur_id]    : '0;
    assign force_last = (beat_cnt == BC_W'(MAX_BEATS - 1));
    assign handshake  = m_valid & m_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked assignment is non-blocking so that all flops sample
    // the pre-edge values of one another, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so that no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (enable) next_state = SEND;
            SEND: if (handshake && m_last) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / strobe logic
    // -------------------------------------------------------------------------
    // The output register refills when it is empty or being emptied this
    // cycle. The head is popped in the same cycle it is captured. Loading
    // stops once a last beat has been captured, so any beats beyond a forced
    // last stay in the queue.
    always_comb begin
        ready    = 1'b0;
        consumed = 1'b0;
        load     = 1'b0;
        pop      = '0;
        unique case (state)
            IDLE: ready = 1'b1;
            SEND: begin
                load = (~m_valid | m_ready) & ~cur_empty & ~last_loaded;
                if (load) pop[cur_id] = 1'b1;
            end
            DONE: consumed = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath, counters and sticky error
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_id          <= '0;
            beat_cnt        <= '0;
            last_loaded     <= 1'b0;
            m_data          <= '0;
            m_last          <= 1'b0;
            m_valid         <= 1'b0;
            beats_forwarded <= '0;
            protocol_error  <= 1'b0;
        end else begin
            if (state == IDLE && enable) begin
                cur_id      <= id;
                beat_cnt    <= '0;
                last_loaded <= 1'b0;
            end

            // A start request while busy is dropped; only the flag records it.
            if (state != IDLE && enable) begin
                protocol_error <= 1'b1;
            end

            if (load) begin
                m_data      <= cur_head;
                m_valid     <= 1'b1;
                m_last      <= cur_last | force_last;
                last_loaded <= cur_last | force_last;
                beat_cnt    <= beat_cnt + BC_W'(1);
            end else if (handshake) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            if (handshake) begin
                beats_forwarded <= beats_forwarded + REGISTER_SIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_transaction_forwarder.sv
// -----------------------------------------------------------------------------
// tb_transaction_forwarder
//
// The bench keeps a model of the four source queues and drives the DUT's
// empty/lastElem/heads from the head of each model queue. When the DUT pops a
// queue, the model queue drops its head. Expected output beats go into a
// scoreboard queue when a transaction is set up. They come off the scoreboard
// whenever the DUT completes an output handshake. The DUT is built with
// MAX_BEATS=4, so a forced last can be reached with a short transaction.
// -----------------------------------------------------------------------------
module tb_transaction_forwarder;

    localparam int NQ  = 4;
    localparam int DW  = 64;
    localparam int MB  = 4;
    localparam int RS  = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic                    clock;
    logic                    reset;
    logic                    enable;
    logic [1:0]              id;
    logic                    ready;
    logic                    consumed;
    logic [NQ-1:0]           empty;
    logic [NQ-1:0]           lastElem;
    logic [NQ-1:0][DW-1:0]   heads;
    logic [NQ-1:0]           pop;
    logic [DW-1:0]           m_data;
    logic                    m_last;
    logic                    m_valid;
    logic                    m_ready;
    logic [RS-1:0]           beats_forwarded;
    logic                    protocol_error;

    transaction_forwarder #(
        .NUMBER_OF_QUEUES (NQ),
        .DATA_WIDTH       (DW),
        .MAX_BEATS        (MB),
        .REGISTER_SIZE    (RS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .id              (id),
        .ready           (ready),
        .consumed        (consumed),
        .empty           (empty),
        .lastElem        (lastElem),
        .heads           (heads),
        .pop             (pop),
        .m_data          (m_data),
        .m_last          (m_last),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .beats_forwarded (beats_forwarded),
        .protocol_error  (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model state and scoreboard
    beat_t      qs [NQ][$];
    beat_t      exp_q [$];
    int         n_checks;
    int         n_errors;
    int         n_hs;
    int         n_consumed;
    int         pops_q [NQ];

    // Observations of the cycle most recently sampled
    logic [NQ-1:0] o_pop;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          o_cons;
    logic          o_ready;

    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic update_inputs();
        for (int i = 0; i < NQ; i++) begin
            if (qs[i].size() == 0) begin
                empty[i]    = 1'b1;
                lastElem[i] = 1'b0;
                heads[i]    = '0;
            end else begin
                empty[i]    = 1'b0;
                lastElem[i] = qs[i][0].last;
                heads[i]    = qs[i][0].data;
            end
        end
    endtask

    // Load n beats into model queue q, numbering the data from base. The
    // final beat carries lastElem when last_end is set.
    task automatic fill_queue(input int q, input int n, input logic [DW-1:0] base, input bit last_end);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + DW'(i);
            b.last = last_end && (i == n - 1);
            qs[q].push_back(b);
        end
        update_inputs();
    endtask

    // Push n expected output beats; the beat at index last_at carries m_last.
    task automatic expect_beats(input int n, input logic [DW-1:0] base, input int last_at);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + DW'(i);
            b.last = (i == last_at);
            exp_q.push_back(b);
        end
    endtask

    // One clock cycle. Inputs are driven at the falling edge. The outputs
    // presented to the next rising edge are then sampled and scored. After
    // that edge, any pops are applied to the model queues.
    task automatic cycle(input logic rdy, input logic en = 1'b0, input logic [1:0] eid = 2'd0);
        logic [NQ-1:0] pend;
        beat_t e;
        @(negedge clock);
        m_ready = rdy;
        enable  = en;
        id      = eid;
        #1;
        o_pop   = pop;
        o_valid = m_valid;
        o_data  = m_data;
        o_last  = m_last;
        o_cons  = consumed;
        o_ready = ready;

        if (prev_stall) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
            check("hold_last", m_last, prev_last);
        end
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
        prev_last  = m_last;

        if (m_valid && m_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_data, e.data);
                check("beat_last", m_last, e.last);
            end
        end
        if (consumed) n_consumed++;

        check("pop_onehot0", $onehot0(pop), 1);
        for (int i = 0; i < NQ; i++) begin
            if (pop[i]) begin
                pops_q[i]++;
                check("pop_nonempty", qs[i].size() != 0, 1);
            end
        end
        pend = pop;

        @(posedge clock);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (pend[i] && qs[i].size() > 0) void'(qs[i].pop_front());
        end
        update_inputs();
    endtask

    // Run until consumed is seen, with m_ready either held high or toggled
    // 1,0,1,0... A missed consumed within the budget counts as a failure.
    task automatic run_until_done(input int budget, input bit toggle);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            cycle(toggle ? ((k % 2) == 0) : 1'b1);
            if (o_cons) seen = 1'b1;
        end
        check("done_in_budget", seen, 1);
    endtask

    int c0;
    int p0;
    int h0;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        n_hs       = 0;
        n_consumed = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        for (int i = 0; i < NQ; i++) pops_q[i] = 0;
        reset   = 1'b0;
        enable  = 1'b0;
        id      = '0;
        m_ready = 1'b0;
        update_inputs();

        // ---------------- reset state ----------------
        #12;
        check("rst_ready", ready, 1);
        check("rst_valid", m_valid, 0);
        check("rst_pop", pop, 0);
        check("rst_consumed", consumed, 0);
        check("rst_beats", beats_forwarded, 0);
        check("rst_perr", protocol_error, 0);
        @(negedge clock);
        reset = 1'b1;
        cycle(1'b1);

        // ---------------- single-beat transaction ----------------
        fill_queue(2, 1, 64'hA5, 1'b1);
        expect_beats(1, 64'hA5, 0);
        cycle(1'b1, 1'b1, 2'd2);                      // t0
        check("sb_t0_ready", o_ready, 1);
        cycle(1'b1);                                  // t1
        check("sb_t1_pop", o_pop, 4'b0100);
        check("sb_t1_valid", o_valid, 0);
        cycle(1'b1);                                  // t2
        check("sb_t2_valid", o_valid, 1);
        check("sb_t2_data", o_data, 64'hA5);
        check("sb_t2_last", o_last, 1);
        check("sb_t2_pop", o_pop, 0);
        cycle(1'b1);                                  // t3
        check("sb_t3_consumed", o_cons, 1);
        check("sb_t3_ready", o_ready, 0);
        cycle(1'b1);                                  // t4
        check("sb_t4_ready", o_ready, 1);
        check("sb_t4_consumed", o_cons, 0);
        check("sb_beats", beats_forwarded, 1);

        // ---------------- 4-beat burst with backpressure ----------------
        c0 = n_consumed;
        p0 = pops_q[1];
        fill_queue(1, 4, 64'h1000, 1'b1);
        expect_beats(4, 64'h1000, 3);
        cycle(1'b1, 1'b1, 2'd1);
        run_until_done(40, 1'b1);
        repeat (2) cycle(1'b1);
        check("bp_pops", pops_q[1] - p0, 4);
        check("bp_consumed", n_consumed - c0, 1);
        check("bp_scoreboard_drained", exp_q.size(), 0);
        check("bp_beats", beats_forwarded, n_hs);

        // ---------------- mid-burst underflow ----------------
        c0 = n_consumed;
        p0 = pops_q[0];
        fill_queue(0, 2, 64'h2000, 1'b0);
        expect_beats(4, 64'h2000, 3);
        cycle(1'b1, 1'b1, 2'd0);
        for (int k = 0; k < 20 && (pops_q[0] - p0) < 2; k++) cycle(1'b1);
        check("uf_pops_before_gap", pops_q[0] - p0, 2);
        repeat (5) cycle(1'b1);
        check("uf_gap_valid_low", o_valid, 0);
        check("uf_gap_no_pop", pops_q[0] - p0, 2);
        check("uf_gap_busy", o_ready, 0);
        fill_queue(0, 2, 64'h2002, 1'b1);
        run_until_done(20, 1'b0);
        repeat (2) cycle(1'b1);
        check("uf_pops", pops_q[0] - p0, 4);
        check("uf_consumed", n_consumed - c0, 1);
        check("uf_scoreboard_drained", exp_q.size(), 0);

        // ---------------- forced last ----------------
        c0 = n_consumed;
        p0 = pops_q[3];
        fill_queue(3, 6, 64'h3000, 1'b1);
        expect_beats(4, 64'h3000, 3);
        cycle(1'b1, 1'b1, 2'd3);
        run_until_done(20, 1'b0);
        repeat (3) cycle(1'b1);
        check("fl_pops", pops_q[3] - p0, 4);
        check("fl_left_in_queue", qs[3].size(), 2);
        check("fl_consumed", n_consumed - c0, 1);
        check("fl_scoreboard_drained", exp_q.size(), 0);
        check("fl_ready", ready, 1);
        qs[3].delete();
        update_inputs();

        // ---------------- protocol error ----------------
        c0 = n_consumed;
        p0 = pops_q[1];
        fill_queue(1, 3, 64'h4000, 1'b1);
        fill_queue(0, 1, 64'h4F00, 1'b1);
        expect_beats(3, 64'h4000, 2);
        check("pe_before", protocol_error, 0);
        cycle(1'b1, 1'b1, 2'd1);
        cycle(1'b1);
        cycle(1'b1, 1'b1, 2'd0);
        run_until_done(20, 1'b0);
        repeat (3) cycle(1'b1);
        check("pe_flag", protocol_error, 1);
        check("pe_pops_q1", pops_q[1] - p0, 3);
        check("pe_q0_untouched", qs[0].size(), 1);
        check("pe_consumed", n_consumed - c0, 1);
        check("pe_scoreboard_drained", exp_q.size(), 0);
        repeat (4) cycle(1'b1);
        check("pe_sticky", protocol_error, 1);
        qs[0].delete();
        update_inputs();

        // ---------------- asynchronous reset mid-burst ----------------
        h0 = n_hs;
        fill_queue(1, 4, 64'h5000, 1'b1);
        expect_beats(4, 64'h5000, 3);
        cycle(1'b1, 1'b1, 2'd1);
        for (int k = 0; k < 20 && (n_hs - h0) < 1; k++) cycle(1'b1);
        check("ar_first_beat_out", n_hs - h0, 1);
        @(negedge clock);
        #2;
        check("ar_pre_valid", m_valid, 1);
        reset = 1'b0;
        #1;
        check("ar_valid", m_valid, 0);
        check("ar_pop", pop, 0);
        check("ar_ready", ready, 1);
        check("ar_beats", beats_forwarded, 0);
        check("ar_data", m_data, 0);
        check("ar_last", m_last, 0);
        check("ar_consumed", consumed, 0);
        check("ar_perr", protocol_error, 0);
        exp_q.delete();
        qs[1].delete();
        update_inputs();
        prev_stall = 1'b0;
        n_hs       = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        c0 = n_consumed;
        repeat (6) cycle(1'b1);
        check("ar_no_consumed", n_consumed - c0, 0);
        check("ar_idle_ready", o_ready, 1);
        check("ar_idle_valid", o_valid, 0);
        check("ar_beats_after", beats_forwarded, 0);

        // ---------------- post-reset transaction ----------------
        fill_queue(2, 2, 64'h6000, 1'b1);
        expect_beats(2, 64'h6000, 1);
        cycle(1'b1, 1'b1, 2'd2);
        run_until_done(20, 1'b0);
        repeat (2) cycle(1'b1);
        check("post_beats", beats_forwarded, 2);
        check("post_scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
